// File: rtl/muldiv_if.sv
// Issue/result handshake bundle between the EX stage (master) and the multiply/divide unit (slave).
// One op per in_valid/in_ready transfer; one result per out_valid/out_ready transfer.
interface muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_src1;
    logic [XLEN-1:0]  in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/muldiv_unit.sv
// Integer MUL/MULH/MULHU (1 cycle) and DIV/MOD/DIVU/MODU (XLEN+1 cycles, radix-2 restoring).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or DONE&out_ready; flush kills.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic clk,
    input  logic resetn,
    input  logic flush,
    output logic busy,
    muldiv_if.slave io
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MOD   = 3'd4;
    localparam logic [2:0] OP_DIVU  = 3'd5;
    localparam logic [2:0] OP_MODU  = 3'd6;
    localparam int         CNT_W    = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t             state, state_nxt;
    logic [2:0]         op_q;
    logic [XLEN-1:0]    a_q;        // multiplicand, or dividend shifting out / quotient shifting in
    logic [XLEN-1:0]    b_q;
    logic [XLEN-1:0]    rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               negq_q, negr_q, dz_q, ovf_q;
    logic [TAG_W-1:0]   tag_q;
    logic [XLEN-1:0]    result_q;

    logic               accept, in_is_div, in_signed, src1_neg, src2_neg;
    logic [XLEN-1:0]    abs1, abs2;
    state_t             start_state;
    logic               mul_signed, is_rem_op;
    logic [2*XLEN-1:0]  ma, mb, prod;
    logic [XLEN-1:0]    mul_res, neg_a, quo_fix, rem_fix;
    logic [XLEN:0]      rem_sh, diff;
    logic               ge;

    assign accept      = io.in_valid & io.in_ready;
    assign in_is_div   = io.in_op inside {OP_DIV, OP_MOD, OP_DIVU, OP_MODU};
    assign in_signed   = (io.in_op == OP_DIV) || (io.in_op == OP_MOD);
    assign src1_neg    = in_signed & io.in_src1[XLEN-1];
    assign src2_neg    = in_signed & io.in_src2[XLEN-1];
    assign abs1        = src1_neg ? -io.in_src1 : io.in_src1;
    assign abs2        = src2_neg ? -io.in_src2 : io.in_src2;
    assign start_state = in_is_div ? S_DIV : S_MUL;

    // Low 2*XLEN bits of the product of sign/zero-extended operands serve both signednesses.
    assign mul_signed = (op_q != OP_MULHU);
    assign ma         = {{XLEN{mul_signed & a_q[XLEN-1]}}, a_q};
    assign mb         = {{XLEN{mul_signed & b_q[XLEN-1]}}, b_q};
    assign prod       = ma * mb;
    assign mul_res    = (op_q == OP_MULH || op_q == OP_MULHU) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

    // One restoring step: the sign of the trial difference decides the quotient bit.
    assign rem_sh  = {rem_q, a_q[XLEN-1]};
    assign diff    = rem_sh - {1'b0, b_q};
    assign ge      = ~diff[XLEN];

    assign is_rem_op = (op_q == OP_MOD) || (op_q == OP_MODU);
    assign neg_a     = -a_q;
    assign quo_fix   = negq_q ? neg_a : a_q;
    assign rem_fix   = negr_q ? -rem_q : rem_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        io.in_ready  = ~flush & ((state == S_IDLE) | ((state == S_DONE) & io.out_ready));
        io.out_valid = (state == S_DONE);
        busy         = (state != S_IDLE);
        case (state)
            S_IDLE: if (accept) state_nxt = start_state;
            S_MUL:  state_nxt = S_DONE;
            S_DIV: begin
                if (dz_q || ovf_q)               state_nxt = S_DONE;
                else if (cnt_q == CNT_W'(1))     state_nxt = S_FIX;
            end
            S_FIX:  state_nxt = S_DONE;
            S_DONE: if (io.out_ready) state_nxt = accept ? start_state : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            tag_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q   <= io.in_op;
            tag_q  <= io.in_tag;
            a_q    <= in_is_div ? abs1 : io.in_src1;
            b_q    <= in_is_div ? abs2 : io.in_src2;
            rem_q  <= '0;
            cnt_q  <= CNT_W'(XLEN);
            negq_q <= src1_neg ^ src2_neg;
            negr_q <= src1_neg;
            dz_q   <= in_is_div && (io.in_src2 == '0);
            ovf_q  <= in_signed && (io.in_src1 == MIN_VAL) && (io.in_src2 == '1);
        end else begin
            case (state)
                S_MUL: result_q <= mul_res;
                S_DIV: begin
                    if (dz_q) begin
                        result_q <= is_rem_op ? (negr_q ? neg_a : a_q) : '1;
                    end else if (ovf_q) begin
                        result_q <= is_rem_op ? '0 : MIN_VAL;
                    end else begin
                        a_q   <= {a_q[XLEN-2:0], ge};
                        rem_q <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_FIX:   result_q <= is_rem_op ? rem_fix : quo_fix;
                default: ;
            endcase
        end
    end

    assign io.out_result = result_q;
    assign io.out_tag    = tag_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: XLEN=32 instance for the main ops, XLEN=16 instance for width scaling.
module tb_muldiv_unit;
    logic clk;
    logic resetn;
    logic flush;
    logic flush16;
    logic busy32;
    logic busy16;
    int   n_tests = 0;
    int   n_fail  = 0;

    muldiv_if #(.XLEN(32), .TAG_W(5)) i32 ();
    muldiv_if #(.XLEN(16), .TAG_W(5)) i16 ();

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .resetn(resetn), .flush(flush), .busy(busy32), .io(i32)
    );
    muldiv_unit #(.XLEN(16), .TAG_W(5)) dut16 (
        .clk(clk), .resetn(resetn), .flush(flush16), .busy(busy16), .io(i16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tg);
        @(negedge clk);
        i32.in_valid = 1'b1;
        i32.in_op    = op;
        i32.in_src1  = a;
        i32.in_src2  = b;
        i32.in_tag   = tg;
        @(posedge clk);
        #1;
        i32.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (i32.out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic take();
        @(negedge clk);
        i32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        i32.out_ready = 1'b0;
    endtask

    task automatic run(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tg,
                       input logic [31:0] exp, input int exp_lat);
        int lat;
        send(op, a, b, tg);
        wait_out(lat);
        chk({nm, "_lat"}, lat, exp_lat);
        chk({nm, "_res"}, i32.out_result, exp);
        chk({nm, "_tag"}, i32.out_tag, tg);
        take();
    endtask

    initial begin
        int lat;
        int seen;
        resetn        = 1'b0;
        flush         = 1'b0;
        flush16       = 1'b0;
        i32.in_valid  = 1'b0;
        i32.in_op     = '0;
        i32.in_src1   = '0;
        i32.in_src2   = '0;
        i32.in_tag    = '0;
        i32.out_ready = 1'b0;
        i16.in_valid  = 1'b0;
        i16.in_op     = '0;
        i16.in_src1   = '0;
        i16.in_src2   = '0;
        i16.in_tag    = '0;
        i16.out_ready = 1'b0;

        #12;
        chk("rst_out_valid", i32.out_valid, 0);
        chk("rst_result", i32.out_result, 0);
        chk("rst_tag", i32.out_tag, 0);
        chk("rst_busy", busy32, 0);
        chk("rst_in_ready", i32.in_ready, 1);
        @(negedge clk);
        resetn = 1'b1;

        // Multiply family and the reserved encoding
        run("mul",    3'd0, 32'hFFFF_FFFF, 32'h2, 5'd3, 32'hFFFF_FFFE, 1);
        run("mulh",   3'd1, 32'hFFFF_FFFF, 32'h2, 5'd4, 32'hFFFF_FFFF, 1);
        run("mulhu",  3'd2, 32'hFFFF_FFFF, 32'h2, 5'd5, 32'h0000_0001, 1);
        run("rsvd",   3'd7, 32'd6,         32'd7, 5'd6, 32'd42,        1);

        // Iterative divide, mixed signs
        run("div_m7_2",  3'd3, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 33);
        run("mod_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 33);
        run("divu_100_7",3'd5, 32'd100,       32'd7,         5'd9,  32'd14,        33);
        run("div_7_m2",  3'd3, 32'd7,         32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 33);
        run("mod_7_m2",  3'd4, 32'd7,         32'hFFFF_FFFE, 5'd11, 32'd1,         33);

        // Special cases resolve without iterating
        run("div_by0",   3'd3, 32'd1234,      32'd0,         5'd12, 32'hFFFF_FFFF, 1);
        run("modu_by0",  3'd6, 32'd5,         32'd0,         5'd13, 32'd5,         1);
        run("mod_by0_s", 3'd4, 32'hFFFF_FFF9, 32'd0,         5'd14, 32'hFFFF_FFF9, 1);
        run("div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
        run("mod_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1);

        // Result held under backpressure, then back-to-back issue on release
        send(3'd0, 32'd5, 32'd6, 5'd12);
        wait_out(lat);
        chk("hold_lat", lat, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", i32.out_valid, 1);
            chk("hold_res", i32.out_result, 30);
            chk("hold_tag", i32.out_tag, 12);
            chk("hold_in_ready", i32.in_ready, 0);
        end
        @(negedge clk);
        i32.in_valid  = 1'b1;
        i32.in_op     = 3'd2;
        i32.in_src1   = 32'h8000_0000;
        i32.in_src2   = 32'd4;
        i32.in_tag    = 5'd13;
        i32.out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", i32.in_ready, 1);
        @(posedge clk);
        #1;
        i32.in_valid  = 1'b0;
        i32.out_ready = 1'b0;
        chk("b2b_valid_drop", i32.out_valid, 0);
        wait_out(lat);
        chk("b2b_lat", lat, 1);
        chk("b2b_res", i32.out_result, 2);
        chk("b2b_tag", i32.out_tag, 13);
        take();

        // Flush mid-divide kills the op; the unit stays usable
        send(3'd3, 32'd1000, 32'd7, 5'd20);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", busy32, 0);
        chk("flush_valid", i32.out_valid, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (i32.out_valid) seen++;
        end
        chk("flush_no_result", seen, 0);
        run("post_flush_mul", 3'd0, 32'd123, 32'd456, 5'd11, 32'h0000_DB18, 1);

        // Asynchronous reset between edges mid-divide
        send(3'd3, 32'd100, 32'd3, 5'd7);
        repeat (5) @(posedge clk);
        #3;
        chk("pre_rst_busy", busy32, 1);
        resetn = 1'b0;
        #1;
        chk("arst_valid", i32.out_valid, 0);
        chk("arst_result", i32.out_result, 0);
        chk("arst_tag", i32.out_tag, 0);
        chk("arst_busy", busy32, 0);
        chk("arst_in_ready", i32.in_ready, 1);
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (i32.out_valid) seen++;
        end
        chk("arst_no_stale", seen, 0);

        // XLEN=16 build
        @(negedge clk);
        i16.in_valid = 1'b1;
        i16.in_op    = 3'd5;
        i16.in_src1  = 16'hFFFF;
        i16.in_src2  = 16'd3;
        i16.in_tag   = 5'd9;
        @(posedge clk);
        #1;
        i16.in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (i16.out_valid) begin
                lat = i;
                break;
            end
        end
        chk("x16_divu_lat", lat, 17);
        chk("x16_divu_res", i16.out_result, 16'h5555);
        chk("x16_divu_tag", i16.out_tag, 9);
        @(negedge clk);
        i16.out_ready = 1'b1;
        @(posedge clk);
        #1;
        i16.out_ready = 1'b0;
        chk("x16_idle", busy16, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
